// File: rtl/cla_mp_add_seq_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer:
// slice width, FSM state encoding and opcode value.
package cla_mp_add_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_mp_add_seq_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carries.
// Purely combinational; of_o is the two's-complement overflow of the slice.
module CLA_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o,
  output logic        of_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    c     = '0;
    gg    = '0;
    gp    = '0;
    c[0]  = cin_i;
    for (int j = 0; j < 8; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Group carries first, then the in-group carries expand from each group's carry-in.
    for (int j = 0; j < 8; j++) begin
      c[4*j+4] = gg[j] | (gp[j] & c[4*j]);
    end
    for (int j = 0; j < 8; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
    end
  end

  assign sum_o  = p ^ c[31:0];
  assign cout_o = c[32];
  assign of_o   = c[32] ^ c[31];

endmodule

// File: rtl/cla_mp_add_seq.sv
// WORDS*32-bit add/subtract sequenced LSB-first through one shared CLA_32bit.
// Result valid WORDS cycles after accept; held stable in DONE until out_ready.
module cla_mp_add_seq
  import cla_mp_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] op_a,
  input  logic [WORD_W*WORDS-1:0] op_b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] result,
  output logic                    cout,
  output logic                    overflow,
  output logic                    busy
);

  localparam int W  = WORD_W * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_e            state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      result_q;
  logic [KW-1:0]     k_q;
  logic              carry_q;
  logic              cout_q;
  logic              of_q;

  logic [WORD_W-1:0] a_sl;
  logic [WORD_W-1:0] b_sl;
  logic [WORD_W-1:0] sum_sl;
  logic              cout_sl;
  logic              of_sl;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (k_q == KW'(w)) begin
        a_sl = a_q[w*WORD_W +: WORD_W];
        b_sl = b_q[w*WORD_W +: WORD_W];
      end
    end
  end

  CLA_32bit u_cla (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (carry_q),
    .sum_o  (sum_sl),
    .cout_o (cout_sl),
    .of_o   (of_sl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1: invert B once here and seed the carry with sub.
            a_q     <= op_a;
            b_q     <= (sub == OP_SUB) ? ~op_b : op_b;
            carry_q <= sub;
            k_q     <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (k_q == KW'(w)) begin
              result_q[w*WORD_W +: WORD_W] <= sum_sl;
            end
          end
          carry_q <= cout_sl;
          if (k_q == K_LAST) begin
            cout_q  <= cout_sl;
            of_q    <= of_sl;
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = of_q;

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Randomized and directed bench for cla_mp_add_seq (WORDS=4) against an
// arithmetic reference model of the full-width add/subtract.
module tb_cla_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_r;
  logic         exp_c;
  logic         exp_o;

  cla_mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact integer arithmetic: unsigned carry/borrow and signed range test.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o);
    logic [W:0]          full;
    logic signed [W+1:0] sa;
    logic signed [W+1:0] sb;
    logic signed [W+1:0] ex;
    sa = {{2{a[W-1]}}, a};
    sb = {{2{b[W-1]}}, b};
    if (s) begin
      r  = a - b;
      c  = (a >= b);
      ex = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[W-1:0];
      c    = full[W];
      ex   = sa + sb;
    end
    o = !((ex[W+1:W-1] == 3'b000) || (ex[W+1:W-1] == 3'b111));
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 4))
      0: v = {W{1'b1}};
      1: v = W'($urandom_range(0, 15));
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  // Drive a request, wait for acceptance, leave the bench on the first negedge after accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int t;
    model(a, b, s, exp_r, exp_c, exp_o);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    sub      = s;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = {$urandom, $urandom, $urandom, $urandom};
    op_b     = {$urandom, $urandom, $urandom, $urandom};
    sub      = 1'($urandom);
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, W'(lat), W'(4));
    check({tag, "_res"}, result, exp_r);
    check({tag, "_cout"}, W'(cout), W'(exp_c));
    check({tag, "_ovf"}, W'(overflow), W'(exp_o));
    check({tag, "_busy"}, W'(busy), W'(1));
    check({tag, "_inrdy"}, W'(in_ready), W'(0));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_vld"}, W'(out_valid), W'(0));
    check({tag, "_idle_rdy"}, W'(in_ready), W'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inrdy"}, W'(in_ready), W'(1));
    check({tag, "_ovld"}, W'(out_valid), W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_res"}, result, '0);
    check({tag, "_cout"}, W'(cout), W'(0));
    check({tag, "_ovf"}, W'(overflow), W'(0));
  endtask

  logic [W-1:0] q_r[$];
  logic         q_c[$];
  logic         q_o[$];

  initial begin
    logic [W-1:0] a, b, held_r;
    logic         s, held_c, held_o;
    int           hold, idx, nout, last_cyc;

    rst       = 1'b1;
    in_valid  = 1'b1;
    op_a      = {W{1'b1}};
    op_b      = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Full-width carry ripple
    issue({W{1'b1}}, W'(1), 1'b0);
    wait_result("ripple");
    check("ripple_const", {result[W-1:0]}, '0);
    check("ripple_cout", W'(cout), W'(1));
    release_out("ripple");

    // Cross-slice carry
    issue(W'(32'hFFFF_FFFF), W'(1), 1'b0);
    wait_result("xslice");
    check("xslice_const", result, W'(64'h1_0000_0000));
    release_out("xslice");

    // Subtraction with borrow, then signed overflow on subtract
    issue(W'(5), W'(7), 1'b1);
    wait_result("borrow");
    check("borrow_const", result, {{(W-2){1'b1}}, 2'b10});
    check("borrow_cout", W'(cout), W'(0));
    release_out("borrow");
    issue({1'b0, {(W-1){1'b1}}}, {W{1'b1}}, 1'b1);
    wait_result("subovf");
    check("subovf_const", result, {1'b1, {(W-1){1'b0}}});
    check("subovf_flag", W'(overflow), W'(1));
    release_out("subovf");

    // Backpressure with a competing request held in DONE
    issue(rnd_op(), rnd_op(), 1'b0);
    wait_result("bp1");
    held_r   = result;
    held_c   = cout;
    held_o   = overflow;
    a        = rnd_op();
    b        = rnd_op();
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    sub      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_res", result, held_r);
      check("bp_hold_cout", W'(cout), W'(held_c));
      check("bp_hold_ovf", W'(overflow), W'(held_o));
      check("bp_hold_inrdy", W'(in_ready), W'(0));
      check("bp_hold_ovld", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_back_idle", W'(in_ready), W'(1));
    model(a, b, 1'b1, exp_r, exp_c, exp_o);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("bp2");
    release_out("bp2");

    // Reset in the middle of RUN, after two slices
    issue({W{1'b1}}, {W{1'b1}}, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("midrun_busy", W'(busy), W'(1));
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(W'(3), W'(4), 1'b0);
    wait_result("after_rst");
    check("after_rst_const", result, W'(7));
    release_out("after_rst");

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    idx       = 0;
    nout      = 0;
    last_cyc  = 0;
    for (int cyc = 0; cyc < 60 && nout < 3; cyc++) begin
      if (out_valid) begin
        check("b2b_res", result, q_r.pop_front());
        check("b2b_cout", W'(cout), W'(q_c.pop_front()));
        check("b2b_ovf", W'(overflow), W'(q_o.pop_front()));
        if (nout > 0) check("b2b_spacing", W'(cyc - last_cyc), W'(6));
        last_cyc = cyc;
        nout++;
      end
      if (in_ready) begin
        if (idx < 3) begin
          a = rnd_op();
          b = rnd_op();
          s = 1'($urandom);
          model(a, b, s, exp_r, exp_c, exp_o);
          q_r.push_back(exp_r);
          q_c.push_back(exp_c);
          q_o.push_back(exp_o);
          in_valid = 1'b1;
          op_a     = a;
          op_b     = b;
          sub      = s;
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b_count", W'(nout), W'(3));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized operations with random consumer stalls
    for (int i = 0; i < 30; i++) begin
      hold = $urandom_range(0, 3);
      issue(rnd_op(), rnd_op(), 1'($urandom));
      wait_result("rand");
      held_r = result;
      repeat (hold) @(negedge clk);
      check("rand_stall_res", result, held_r);
      release_out("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cla_mp_add_seq.md
Name: cla_mp_add_seq

Overview:
Multi-cycle, multi-precision add/subtract sequencer built around one shared 32-bit carry-lookahead adder (CLA_32bit).
- Accepts WORDS*32-bit operands over a valid/ready handshake.
- Issues one 32-bit slice per cycle, least-significant first, chaining the carry through a register.
- Returns the full-width result, carry-out and signed overflow over a second valid/ready handshake.
- Sits between the execute-stage issue logic and wide-arithmetic consumers, where a full-width combinational adder is too large.

Parameters:
WORDS, 4, number of 32-bit slices; operand width = 32*WORDS; legal range 2..16.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept a request
op_a  in  32*WORDS  operand A
op_b  in  32*WORDS  operand B
sub  in  1  0 = A+B, 1 = A-B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  32*WORDS  sum/difference
cout  out  1  final carry-out (for sub: 1 = no borrow)
overflow  out  1  signed overflow of full-width operation
busy  out  1  high in RUN or DONE

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- States: IDLE, RUN, DONE. rst forces IDLE from any state, including mid-RUN; no partial result is ever presented.
- Reset values:
  - in_ready=1, out_valid=0, busy=0.
  - result=0, cout=0, overflow=0.
  - Word counter k=0, carry register=0.
- Outputs are decoded from state: in_ready=(IDLE), out_valid=(DONE), busy=(RUN|DONE). No combinational path from in_valid or out_ready to any output.
- IDLE:
  - On in_valid & in_ready: latch op_a into A_reg, and (sub ? ~op_b : op_b) into B_reg.
  - Set carry=sub, k=0, go to RUN.
  - Inputs are not sampled after the accepting edge.
- RUN, each cycle:
  - Drive the adder with A_reg[32k+31:32k], B_reg[32k+31:32k] and carry.
  - Write the 32-bit sum into result[32k+31:32k] and set carry <= adder cout.
  - When k = WORDS-1: also latch cout and overflow (overflow from the top slice's OF term, computed against the possibly-inverted B slice), then go to DONE. Otherwise k <= k+1.
  - The counter is $clog2(WORDS) bits and never wraps past WORDS-1.
- DONE:
  - result, cout and overflow are held stable while out_valid=1 and out_ready=0.
  - in_valid is ignored.
  - On out_ready go to IDLE. result, cout and overflow keep their values until the next RUN overwrites them.
- Latency: out_valid rises WORDS cycles after the accepting edge.
- Throughput: one operation per WORDS+2 cycles when out_ready is held high.
- result slices not yet written in RUN hold stale data. This is not observable, because out_valid=0.
- in_valid asserted during reset is ignored. After reset deasserts, the first rising edge with in_valid=1 is accepted.
- Width rules: all arithmetic is modulo 2^(32*WORDS). Subtraction is A + ~B + 1.

Decomposition:
- Shared package:
  - WORD_W=32.
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Opcode constant OP_SUB=1'b1.
- One sub-module: the existing CLA_32bit, instantiated once as the shared datapath.
- Slice muxing, carry register, counter and FSM live in cla_mp_add_seq.

Test Plan:
All scenarios use WORDS=4.
1. Full-width carry ripple: A=2^128-1, B=1, sub=0 -> result=0, cout=1, overflow=0; out_valid first high 4 cycles after accept.
2. Cross-slice carry: A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1 -> result=0x...0001_0000_0000, cout=0, overflow=0.
3. Subtraction with borrow: A=5, B=7, sub=1 -> result=0xFFFF...FFFE, cout=0, overflow=0. Then A=0x7FFF...FFFF, B=0xFFFF...FFFF (=-1), sub=1 -> result=0x8000...0000, overflow=1.
4. Backpressure: out_ready held 0 for 3 cycles in DONE while in_valid=1 with new operands -> result, cout and overflow unchanged; in_ready=0; the new request is taken only after out_ready and the return to IDLE.
5. Reset mid-RUN: assert rst after 2 slices processed -> all outputs return to reset values immediately (asynchronously). Next request A=3, B=4 -> result=7 with correct latency.
6. Back-to-back: in_valid and out_ready held high with 3 different operand pairs -> 3 correct results spaced exactly 6 cycles apart.
